alu_issue_stage: RTL and testbench

- Front-end feeder for the ALU: buffers 16-bit ALU instructions in a small FIFO, decodes the head entry and reads register operands.
- Presents the decoded bundle to the ALU on its native port set: alusignals, op1, op2, immx, isimmediate.
- Sits between fetch/dispatch and the ALU, with a valid/ready handshake on both sides.

---
 rtl/alu_issue_stage.sv | 155 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - instruction queue, decode and operand read feeding the ALU
// Head entry is decoded combinationally; the issue register holds the bundle until the ALU takes it.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_instr,
  output logic [2:0]      rf_raddr1,
  output logic [2:0]      rf_raddr2,
  input  logic [15:0]     rf_rdata1,
  input  logic [15:0]     rf_rdata2,
  input  logic            alu_ready,
  output logic            issue_valid,
  output logic [12:0]     alusignals,
  output logic [15:0]     op1,
  output logic [15:0]     op2,
  output logic [4:0]      immx,
  output logic            isimmediate,
  output logic [2:0]      issue_rd,
  output logic            illegal,
  output logic [CNTW-1:0] queue_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic            issue_valid_q, issue_valid_d;
  logic [12:0]     alusignals_q, alusignals_d;
  logic [15:0]     op1_q, op1_d;
  logic [15:0]     op2_q, op2_d;
  logic [4:0]      immx_q, immx_d;
  logic            isimmediate_q, isimmediate_d;
  logic [2:0]      issue_rd_q, issue_rd_d;
  logic            illegal_q, illegal_d;

  logic [15:0] head;
  logic [12:0] sig_dec;
  logic        legal;
  logic        push, pop, adv;

  assign head      = mem_q[rd_ptr_q];
  assign rf_raddr1 = head[7:5];
  assign rf_raddr2 = head[2:0];

  always_comb begin
    sig_dec = '0;
    legal   = 1'b1;
    case (head[15:12])
      4'd0:    sig_dec[0]  = 1'b1;
      4'd1:    sig_dec[3]  = 1'b1;
      4'd2:    sig_dec[4]  = 1'b1;
      4'd3:    sig_dec[5]  = 1'b1;
      4'd4:    sig_dec[6]  = 1'b1;
      4'd5:    sig_dec[7]  = 1'b1;
      4'd6:    sig_dec[8]  = 1'b1;
      4'd7:    sig_dec[9]  = 1'b1;
      4'd8:    sig_dec[10] = 1'b1;
      4'd9:    sig_dec[11] = 1'b1;
      default: legal       = 1'b0;
    endcase
  end

  // in_ready deliberately ignores a same-cycle pop so it never depends on alu_ready.
  assign in_ready = !rst && (count_q < CNTW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign adv      = !issue_valid_q || alu_ready;
  assign pop      = (count_q != '0) && adv;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_instr;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CNTW'(push) - CNTW'(pop);
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    alusignals_d  = alusignals_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    immx_d        = immx_q;
    isimmediate_d = isimmediate_q;
    issue_rd_d    = issue_rd_q;
    illegal_d     = 1'b0;
    if (adv) begin
      issue_valid_d = 1'b0;
      if (pop) begin
        if (legal) begin
          issue_valid_d = 1'b1;
          alusignals_d  = sig_dec;
          op1_d         = rf_rdata1;
          op2_d         = head[11] ? 16'h0000 : rf_rdata2;
          immx_d        = head[11] ? head[4:0] : 5'd0;
          isimmediate_d = head[11];
          issue_rd_d    = head[10:8];
        end else begin
          illegal_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      alusignals_q  <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      immx_q        <= '0;
      isimmediate_q <= 1'b0;
      issue_rd_q    <= '0;
      illegal_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      alusignals_q  <= alusignals_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      immx_q        <= immx_d;
      isimmediate_q <= isimmediate_d;
      issue_rd_q    <= issue_rd_d;
      illegal_q     <= illegal_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign alusignals  = alusignals_q;
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign immx        = immx_q;
  assign isimmediate = isimmediate_q;
  assign issue_rd    = issue_rd_q;
  assign illegal     = illegal_q;
  assign queue_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
// Stimulus pushes expected bundles into a queue; a negedge monitor pops them on each handshake.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  rf_raddr1, rf_raddr2;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic        alu_ready;
  logic        issue_valid;
  logic [12:0] alusignals;
  logic [15:0] op1, op2;
  logic [4:0]  immx;
  logic        isimmediate;
  logic [2:0]  issue_rd;
  logic        illegal;
  logic [2:0]  queue_count;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(4), .CNTW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_ready(alu_ready), .issue_valid(issue_valid), .alusignals(alusignals), .op1(op1),
    .op2(op2), .immx(immx), .isimmediate(isimmediate), .issue_rd(issue_rd),
    .illegal(illegal), .queue_count(queue_count)
  );

  logic [15:0] regs [8];
  initial begin
    regs[0] = 16'h1000; regs[1] = 16'h2001; regs[2] = 16'h0005; regs[3] = 16'h0003;
    regs[4] = 16'h4004; regs[5] = 16'h5005; regs[6] = 16'h6006; regs[7] = 16'h7007;
  end
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  typedef struct packed {
    logic        ill;
    logic [53:0] b;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [12:0] s, input logic [15:0] a, input logic [15:0] b,
                              input logic [4:0] im, input logic isi, input logic [2:0] rd);
    exp_t e;
    e.ill = 1'b0;
    e.b   = {s, a, b, im, isi, rd};
    return e;
  endfunction

  function automatic exp_t mk_ill();
    exp_t e;
    e.ill = 1'b1;
    e.b   = '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] ins, input exp_t e);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 64'd1, 64'd0);
    @(posedge clk);
    exp_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: handshakes, illegal pulses and stall stability.
  logic        prev_stall = 1'b0;
  logic [53:0] prev_b;
  logic [53:0] cur_b;
  always @(negedge clk) begin
    cur_b = {alusignals, op1, op2, immx, isimmediate, issue_rd};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(issue_valid), 64'd1);
        chk("stall_hold", 64'(cur_b), 64'(prev_b));
      end
      if (illegal) begin
        if (exp_q.size() == 0) chk("illegal_unexpected", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("illegal_order", 64'(e.ill), 64'd1);
        end
      end
      if (issue_valid && alu_ready) begin
        if (exp_q.size() == 0) chk("issue_unexpected", 64'(cur_b), 64'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("issue_not_illegal", 64'(e.ill), 64'd0);
          chk("issue_bundle", 64'(cur_b), 64'(e.b));
        end
      end
      prev_stall = issue_valid && !alu_ready;
      prev_b     = cur_b;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 16'h0153;
    alu_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_outputs", 64'({issue_valid, alusignals, op1, op2, immx, isimmediate, issue_rd, illegal}), 64'd0);
    repeat (2) @(negedge clk);
    chk("reset_instr_discarded", 64'(queue_count), 64'd0);

    // add r1,r2,r3 and latency
    @(posedge clk);
    #1 alu_ready = 1'b1;
    push(16'h0153, mk(13'h0001, 16'h0005, 16'h0003, 5'd0, 1'b0, 3'd1));
    @(negedge clk);
    chk("latency_n", 64'(issue_valid), 64'd0);
    @(negedge clk);
    chk("latency_n1", 64'(issue_valid), 64'd1);
    drain();

    // lsl r0,r1,#3
    @(posedge clk); #1;
    push(16'h8823, mk(13'h0400, 16'h2001, 16'h0000, 5'd3, 1'b1, 3'd0));
    drain();

    // stall with five pushes, then back-to-back drain
    @(posedge clk);
    #1 alu_ready = 1'b0;
    push(16'h1285, mk(13'h0008, 16'h4004, 16'h5005, 5'd0,  1'b0, 3'd2));
    push(16'h23C7, mk(13'h0010, 16'h6006, 16'h7007, 5'd0,  1'b0, 3'd3));
    push(16'h5F1F, mk(13'h0080, 16'h1000, 16'h0000, 5'd31, 1'b1, 3'd7));
    push(16'h6422, mk(13'h0100, 16'h2001, 16'h0005, 5'd0,  1'b0, 3'd4));
    push(16'h9D70, mk(13'h0800, 16'h0003, 16'h0000, 5'd16, 1'b1, 3'd5));
    @(negedge clk);
    chk("full_count", 64'(queue_count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_issue_valid", 64'(issue_valid), 64'd1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 alu_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("back_to_back", 64'(issue_valid), 64'd1);
    end
    drain();
    @(negedge clk);
    chk("drained_count", 64'(queue_count), 64'd0);

    // illegal opcode then sub
    @(posedge clk); #1;
    push(16'hF000, mk_ill());
    push(16'h1000, mk(13'h0008, 16'h1000, 16'h1000, 5'd0, 1'b0, 3'd0));
    drain();

    // back-to-back mix including opcode 10 boundary
    @(posedge clk); #1;
    push(16'h36E1, mk(13'h0020, 16'h7007, 16'h2001, 5'd0, 1'b0, 3'd6));
    push(16'hA000, mk_ill());
    push(16'h4905, mk(13'h0040, 16'h1000, 16'h0000, 5'd5, 1'b1, 3'd1));
    push(16'h70A0, mk(13'h0200, 16'h5005, 16'h1000, 5'd0, 1'b0, 3'd0));
    drain();

    // reset while stalled with three queued
    @(posedge clk);
    #1 alu_ready = 1'b0;
    push(16'h0153, mk(13'h0001, 16'h0005, 16'h0003, 5'd0, 1'b0, 3'd1));
    push(16'h1285, mk(13'h0008, 16'h4004, 16'h5005, 5'd0, 1'b0, 3'd2));
    push(16'h23C7, mk(13'h0010, 16'h6006, 16'h7007, 5'd0, 1'b0, 3'd3));
    push(16'h6422, mk(13'h0100, 16'h2001, 16'h0005, 5'd0, 1'b0, 3'd4));
    @(negedge clk);
    chk("pre_reset_count", 64'(queue_count), 64'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_valid", 64'(issue_valid), 64'd0);
    chk("mid_reset_count", 64'(queue_count), 64'd0);
    #1 alu_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_idle", 64'({issue_valid, illegal, queue_count}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
